fp_issue_q: RTL and testbench

FP_ISSUE_Q -- requirements
Module: fp_issue_q

---
 rtl/fp_issue_q.sv | 177 +++++++++++++++++
 tb/tb_fp_issue_q.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_issue_q.sv
// Operand issue queue for a fixed-latency FP mul/add datapath.
// A credit scheme reserves a result-FIFO slot for every in-flight op, so results are never dropped.
module fp_issue_q #(
  parameter int unsigned SIGN_W = 1,
  parameter int unsigned EXPO_W = 8,
  parameter int unsigned MANT_W = 23,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LAT    = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SIGN_W+EXPO_W+MANT_W-1:0]  in_a,
  input  logic [SIGN_W+EXPO_W+MANT_W-1:0]  in_b,
  input  logic [1:0]                       in_rnd,
  input  logic                             in_op,
  output logic                             iss_valid,
  output logic [SIGN_W+EXPO_W+MANT_W-1:0]  iss_a,
  output logic [SIGN_W+EXPO_W+MANT_W-1:0]  iss_b,
  output logic [1:0]                       iss_rnd,
  output logic                             iss_op,
  input  logic [SIGN_W+EXPO_W+MANT_W-1:0]  dp_res,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SIGN_W+EXPO_W+MANT_W-1:0]  out_res,
  output logic                             out_op
);

  localparam int unsigned W      = SIGN_W + EXPO_W + MANT_W;
  localparam int unsigned RDEPTH = LAT + 2;
  localparam int unsigned QAW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned QCW    = $clog2(DEPTH + 1);
  localparam int unsigned RAW    = $clog2(RDEPTH);
  localparam int unsigned RCW    = $clog2(RDEPTH + 1);
  localparam int unsigned FW     = $clog2(LAT + RDEPTH + 1);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   rnd;
    logic         op;
  } opnd_t;

  typedef struct packed {
    logic [W-1:0] res;
    logic         op;
  } res_t;

  opnd_t            q_mem_q [DEPTH];
  opnd_t            q_mem_d [DEPTH];
  logic [QAW-1:0]   q_wr_q, q_wr_d, q_rd_q, q_rd_d;
  logic [QCW-1:0]   q_cnt_q, q_cnt_d;

  res_t             r_mem_q [RDEPTH];
  res_t             r_mem_d [RDEPTH];
  logic [RAW-1:0]   r_wr_q, r_wr_d, r_rd_q, r_rd_d;
  logic [RCW-1:0]   r_cnt_q, r_cnt_d;

  logic [LAT-1:0]   sr_v_q, sr_v_d, sr_op_q, sr_op_d;
  opnd_t            iss_q, iss_d;
  logic             iss_valid_q, iss_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             q_push_c, q_pop_c, r_push_c, r_pop_c, credit_c;
  logic [FW-1:0]    inflight_c;

  // Credit counts reserved slots only; a result popped this cycle frees credit next cycle.
  always_comb begin
    inflight_c = '0;
    for (int unsigned i = 0; i < LAT; i++) begin
      inflight_c = inflight_c + FW'(sr_v_q[i]);
    end
    credit_c = (inflight_c + FW'(r_cnt_q)) < FW'(RDEPTH);
    q_push_c = in_valid && (q_cnt_q < QCW'(DEPTH));
    q_pop_c  = (q_cnt_q != '0) && credit_c;
    r_push_c = sr_v_q[LAT-1];
    r_pop_c  = (r_cnt_q != '0) && out_ready;
  end

  // Operand queue and issue register.
  always_comb begin
    q_mem_d     = q_mem_q;
    q_wr_d      = q_wr_q;
    q_rd_d      = q_rd_q;
    iss_d       = iss_q;
    iss_valid_d = q_pop_c;
    if (q_push_c) begin
      q_mem_d[q_wr_q] = '{a: in_a, b: in_b, rnd: in_rnd, op: in_op};
      q_wr_d          = q_wr_q + QAW'(1);
    end
    if (q_pop_c) begin
      iss_d  = q_mem_q[q_rd_q];
      q_rd_d = q_rd_q + QAW'(1);
    end
    q_cnt_d    = q_cnt_q + QCW'(q_push_c) - QCW'(q_pop_c);
    in_ready_d = q_cnt_d < QCW'(DEPTH);
  end

  // In-flight tracker: stage LAT-1 marks the cycle whose closing edge samples dp_res.
  always_comb begin
    sr_v_d     = '0;
    sr_op_d    = '0;
    sr_v_d[0]  = q_pop_c;
    sr_op_d[0] = q_mem_q[q_rd_q].op;
    for (int unsigned i = 1; i < LAT; i++) begin
      sr_v_d[i]  = sr_v_q[i-1];
      sr_op_d[i] = sr_op_q[i-1];
    end
  end

  // Result FIFO; RDEPTH need not be a power of two, so pointers wrap explicitly.
  always_comb begin
    r_mem_d = r_mem_q;
    r_wr_d  = r_wr_q;
    r_rd_d  = r_rd_q;
    if (r_push_c) begin
      r_mem_d[r_wr_q] = '{res: dp_res, op: sr_op_q[LAT-1]};
      r_wr_d          = (r_wr_q == RAW'(RDEPTH - 1)) ? '0 : r_wr_q + RAW'(1);
    end
    if (r_pop_c) begin
      r_rd_d = (r_rd_q == RAW'(RDEPTH - 1)) ? '0 : r_rd_q + RAW'(1);
    end
    r_cnt_d     = r_cnt_q + RCW'(r_push_c) - RCW'(r_pop_c);
    out_valid_d = r_cnt_d != '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_mem_q[i] <= '0;
      end
      for (int unsigned i = 0; i < RDEPTH; i++) begin
        r_mem_q[i] <= '0;
      end
      q_wr_q      <= '0;
      q_rd_q      <= '0;
      q_cnt_q     <= '0;
      r_wr_q      <= '0;
      r_rd_q      <= '0;
      r_cnt_q     <= '0;
      sr_v_q      <= '0;
      sr_op_q     <= '0;
      iss_q       <= '0;
      iss_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      q_mem_q     <= q_mem_d;
      r_mem_q     <= r_mem_d;
      q_wr_q      <= q_wr_d;
      q_rd_q      <= q_rd_d;
      q_cnt_q     <= q_cnt_d;
      r_wr_q      <= r_wr_d;
      r_rd_q      <= r_rd_d;
      r_cnt_q     <= r_cnt_d;
      sr_v_q      <= sr_v_d;
      sr_op_q     <= sr_op_d;
      iss_q       <= iss_d;
      iss_valid_q <= iss_valid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign iss_valid = iss_valid_q;
  assign iss_a     = iss_q.a;
  assign iss_b     = iss_q.b;
  assign iss_rnd   = iss_q.rnd;
  assign iss_op    = iss_q.op;
  assign out_valid = out_valid_q;
  assign out_res   = r_mem_q[r_rd_q].res;
  assign out_op    = r_mem_q[r_rd_q].op;

endmodule

// File: tb/tb_fp_issue_q.sv
// Bench for fp_issue_q: stand-in datapath, acceptance-time scoreboard, per-feature tasks.
module tb_fp_issue_q;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = 2;

  typedef struct packed {
    logic [W-1:0] res;
    logic         op;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, in_op, iss_valid, iss_op;
  logic         out_valid, out_ready, out_op;
  logic [W-1:0] in_a, in_b, iss_a, iss_b, dp_res, out_res;
  logic [1:0]   in_rnd, iss_rnd;

  int   checks = 0, failures = 0;
  int   n_acc = 0, n_iss = 0, n_pop = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic hold_v = 1'b0, iss_prev_v = 1'b0;
  logic [W-1:0] hold_res;
  logic hold_op;
  logic [2*W+2:0] iss_prev;

  logic         dp_stage_v = 1'b0;
  logic [W-1:0] dp_stage = '0;

  fp_issue_q #(.SIGN_W(1), .EXPO_W(8), .MANT_W(23), .DEPTH(4), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_rnd(in_rnd), .in_op(in_op),
    .iss_valid(iss_valid), .iss_a(iss_a), .iss_b(iss_b), .iss_rnd(iss_rnd), .iss_op(iss_op),
    .dp_res(dp_res), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_op(out_op)
  );

  always #5 clk = ~clk;

  // Stand-in datapath: multiply by 1.0 returns b exactly, other cases are arbitrary but deterministic.
  function automatic logic [W-1:0] dp_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic op);
    if (op) return a + b;
    if (a == 32'h3F80_0000) return b;
    return a ^ {b[W-2:0], 1'b1};
  endfunction

  // One register stage gives LAT=2; idle cycles drive a poison value that must never surface.
  always @(posedge clk) begin
    dp_stage_v <= iss_valid;
    dp_stage   <= dp_model(iss_a, iss_b, iss_op);
  end
  assign dp_res = dp_stage_v ? dp_stage : 32'hDEAD_BEEF;

  // Monitor: push expectations on acceptance, compare on result pop, check hold behaviour.
  always @(negedge clk) begin
    if (!rst) begin
      if (iss_valid) n_iss++;
      if (!iss_valid && iss_prev_v) begin
        checks++;
        if ({iss_a, iss_b, iss_rnd, iss_op} !== iss_prev) begin
          failures++;
          $display("FAIL iss_hold got=%h exp=%h", {iss_a, iss_b, iss_rnd, iss_op}, iss_prev);
        end
      end
      iss_prev   = {iss_a, iss_b, iss_rnd, iss_op};
      iss_prev_v = 1'b1;
      if (in_valid && in_ready) begin
        sb.push_back('{res: dp_model(in_a, in_b, in_op), op: in_op});
        n_acc++;
      end
      if (hold_v) begin
        checks++;
        if (!out_valid || out_res !== hold_res || out_op !== hold_op) begin
          failures++;
          $display("FAIL out_stable got=%b/%h/%b exp=1/%h/%b", out_valid, out_res, out_op,
                   hold_res, hold_op);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        n_pop++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL result_unexpected got=%h/%b exp=none", out_res, out_op);
        end else begin
          mon_e = sb.pop_front();
          if (out_res !== mon_e.res || out_op !== mon_e.op) begin
            failures++;
            $display("FAIL result got=%h/%b exp=%h/%b", out_res, out_op, mon_e.res, mon_e.op);
          end
        end
      end
      hold_v   = out_valid && !out_ready;
      hold_res = out_res;
      hold_op  = out_op;
    end else begin
      hold_v     = 1'b0;
      iss_prev_v = 1'b0;
    end
  end

  task automatic drive_rand();
    in_valid = 1'b1;
    in_a     = $urandom;
    in_b     = $urandom;
    in_rnd   = 2'($urandom);
    in_op    = 1'($urandom);
  endtask

  // Drives tuples with out_ready low until 8 are accepted (or the budget runs out).
  task automatic fill_queue();
    int base, budget;
    out_ready = 1'b0;
    base      = n_acc;
    budget    = 0;
    @(posedge clk); #1;
    drive_rand();
    while (n_acc - base < 8 && budget < 40) begin
      @(posedge clk); #1;
      budget++;
      drive_rand();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain_timeout got=%0d pending exp=0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_rnd = '0; in_op = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({iss_valid, out_valid, out_res, out_op, iss_a, iss_b, iss_rnd, iss_op} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {iss_valid, out_valid, out_res, out_op, iss_a, iss_b, iss_rnd, iss_op});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, iss_valid, out_valid} !== 3'b100) begin
      failures++;
      $display("FAIL reset_release got=%b exp=100", {in_ready, iss_valid, out_valid});
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 32'h3F80_0000; in_b = 32'h4000_0000; in_rnd = 2'd0; in_op = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (iss_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_iss_c0 got=%b exp=0", iss_valid);
    end
    @(negedge clk);
    checks++;
    if ({iss_valid, iss_a, iss_b, iss_rnd, iss_op} !== {1'b1, 32'h3F80_0000, 32'h4000_0000, 3'b000}) begin
      failures++;
      $display("FAIL single_iss_c1 got=%b/%h/%h/%h/%b exp=1/3f800000/40000000/0/0",
               iss_valid, iss_a, iss_b, iss_rnd, iss_op);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_out_c2 got=%b exp=0", out_valid);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_res, out_op} !== {1'b1, 32'h4000_0000, 1'b0}) begin
      failures++;
      $display("FAIL single_out_c3 got=%b/%h/%b exp=1/40000000/0", out_valid, out_res, out_op);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_out_c4 got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int base_acc, base_pop;
    logic exp_v;
    base_acc = n_acc; base_pop = n_pop;
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive_rand(); in_op = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c < 7) begin
        drive_rand(); in_op = 1'(c);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      exp_v = (c >= 3 && c <= 10);
      checks++;
      if (out_valid !== exp_v) begin
        failures++;
        $display("FAIL stream_out_valid_c%0d got=%b exp=%b", c, out_valid, exp_v);
      end
    end
    checks++;
    if (n_acc - base_acc != 8 || n_pop - base_pop != 8) begin
      failures++;
      $display("FAIL stream_counts got=%0d/%0d exp=8/8", n_acc - base_acc, n_pop - base_pop);
    end
  endtask

  task automatic test_backpressure();
    int base_acc, base_iss, base_pop;
    base_acc = n_acc; base_iss = n_iss; base_pop = n_pop;
    fill_queue();
    drive_rand();
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_full got=in_ready %b out_valid %b exp=0/1", in_ready, out_valid);
    end
    checks++;
    if (n_acc - base_acc != 8) begin
      failures++;
      $display("FAIL bp_accepts got=%0d exp=8", n_acc - base_acc);
    end
    checks++;
    if (n_iss - base_iss != 4) begin
      failures++;
      $display("FAIL bp_issued got=%0d exp=4", n_iss - base_iss);
    end
    in_valid = 1'b0;
    wait_drain("bp");
    checks++;
    if (n_pop - base_pop != 8) begin
      failures++;
      $display("FAIL bp_results got=%0d exp=8", n_pop - base_pop);
    end
  endtask

  task automatic test_full_boundary();
    int   acc_before, budget;
    logic ir_before;
    fill_queue();
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive_rand();
    budget = 0;
    ir_before = in_ready; acc_before = n_acc;
    do begin
      ir_before  = in_ready;
      acc_before = n_acc;
      @(posedge clk); #1;
      budget++;
    end while (!iss_valid && budget < 10);
    checks++;
    if (ir_before !== 1'b0 || n_acc != acc_before || !iss_valid) begin
      failures++;
      $display("FAIL full_pop_edge got=ready %b accepted %0d issued %b exp=0/0/1",
               ir_before, n_acc - acc_before, iss_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_ready_after got=%b exp=1", in_ready);
    end
    acc_before = n_acc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (n_acc - acc_before != 1) begin
      failures++;
      $display("FAIL full_accept_next got=%0d exp=1", n_acc - acc_before);
    end
    wait_drain("full");
  endtask

  task automatic test_reset_midflight();
    int budget;
    logic seen;
    out_ready = 1'b0;
    @(posedge clk); #1;
    drive_rand();
    repeat (2) begin
      @(posedge clk); #1;
      drive_rand();
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    budget = 0;
    while (!out_valid && budget < 10) begin
      @(posedge clk); #1;
      budget++;
    end
    checks++;
    if (out_valid !== 1'b1 || budget != 1) begin
      failures++;
      $display("FAIL midrst_setup got=out_valid %b after %0d exp=1 after 1", out_valid, budget);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if ({out_valid, iss_valid, in_ready} !== 3'b001) begin
      failures++;
      $display("FAIL midrst_state got=%b exp=001", {out_valid, iss_valid, in_ready});
    end
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL midrst_stale got=%b exp=0", seen);
    end
  endtask

  task automatic test_random();
    int base_acc, base_pop, sent;
    base_acc = n_acc; base_pop = n_pop;
    sent = 0;
    for (int c = 0; c < 150 && (n_acc - base_acc) < 40; c++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 9) < 7) drive_rand();
      else in_valid = 1'b0;
      sent++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain("random");
    checks++;
    if (n_pop - base_pop != n_acc - base_acc || sent == 0) begin
      failures++;
      $display("FAIL random_counts got=%0d results exp=%0d", n_pop - base_pop, n_acc - base_acc);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_full_boundary();
    test_reset_midflight();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL final_pending got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
